// File: rtl/charge_pkg.sv
// Shared types and helpers for the charge-enable arbiter.
//   state_t  : arbiter FSM encoding (IDLE, DEAD, CHARGE)
//   rr_pick  : round-robin search, first set request above ptr with wrap
package charge_pkg;

  localparam int MAX_CH   = 8;
  localparam int CH_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DEAD   = 2'd1,
    ST_CHARGE = 2'd2
  } state_t;

  // Searches ptr+1, ptr+2, ... (mod n) and returns the first set index.
  // Walking k downward lets the smallest distance overwrite the result last.
  // Caller guarantees at least one bit of pend[n-1:0] is set.
  function automatic logic [CH_IDX_W-1:0] rr_pick(
    input logic [MAX_CH-1:0]   pend,
    input logic [CH_IDX_W-1:0] ptr,
    input int                  n
  );
    logic [CH_IDX_W-1:0] res;
    int                  idx;
    res = ptr;
    for (int k = MAX_CH; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && pend[idx[CH_IDX_W-1:0]]) res = idx[CH_IDX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick generator.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   clr                : hold counter at 0 and suppress tick
//   tick               : one-cycle pulse every CLK_PER_US cycles while !clr
module us_tick_gen #(
  parameter int CLK_PER_US = 50
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !clr && (cnt_q == CW'(CLK_PER_US - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/charge_enable_arbiter.sv
// N-channel capacitor-charge enable arbiter.
// Latches key-press requests, grants one channel's charge IGBT at a time in
// round-robin order, inserts a dead-time before every grant and ends a charge
// on abort, driver fault, timeout or voltage reached.
//   key_push    : request keys (synchronised level, rising edge requests)
//   volt_ok     : per-channel setpoint reached
//   fault       : per-channel IGBT driver fault
//   abort_all   : drop everything, back to IDLE
//   err_clr     : clear sticky fault_lat / timeout_err
//   charge_en   : registered one-hot-or-zero IGBT enables
//   pend        : latched pending requests
//   busy        : FSM not in IDLE
//   fault_lat   : sticky fault per channel
//   timeout_err : sticky timeout per channel
module charge_enable_arbiter
  import charge_pkg::*;
#(
  parameter int N_CH       = 3,
  parameter int CLK_PER_US = 50,
  parameter int DEAD_CLK   = 4,
  parameter int TIMEOUT_US = 500000,
  parameter int TMR_W      = 20
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [N_CH-1:0] key_push,
  input  logic [N_CH-1:0] volt_ok,
  input  logic [N_CH-1:0] fault,
  input  logic            abort_all,
  input  logic            err_clr,
  output logic [N_CH-1:0] charge_en,
  output logic [N_CH-1:0] pend,
  output logic            busy,
  output logic [N_CH-1:0] fault_lat,
  output logic [N_CH-1:0] timeout_err
);

  localparam int IW = CH_IDX_W;
  localparam int DW = $clog2(DEAD_CLK + 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     sel_q, sel_d, ptr_q, ptr_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [TMR_W-1:0]  us_q, us_d;
  logic [N_CH-1:0]   key_q;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [N_CH-1:0]   flt_q, flt_d;
  logic [N_CH-1:0]   tmo_q, tmo_d;
  logic [N_CH-1:0]   en_q, en_d;

  logic [N_CH-1:0]   sel_oh, sel_mask, key_rise, cand;
  logic [MAX_CH-1:0] cand_ext;
  logic              us_tick, f_sel, v_sel, tmo_hit;

  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (state_q != ST_CHARGE),
    .tick     (us_tick)
  );

  assign sel_oh   = N_CH'(1) << sel_q;
  // A channel that is being served cannot re-request until it is released.
  assign sel_mask = (state_q != ST_IDLE) ? sel_oh : '0;
  assign key_rise = key_push & ~key_q;
  // A channel faulting this very cycle must not be picked.
  assign cand     = pend_q & ~fault;
  assign f_sel    = |(fault & sel_oh);
  assign v_sel    = |(volt_ok & sel_oh);
  // Fires on the tick that brings the microsecond count to TIMEOUT_US.
  assign tmo_hit  = us_tick && (us_q == TMR_W'(TIMEOUT_US - 1));

  always_comb begin
    cand_ext             = '0;
    cand_ext[N_CH-1:0]   = cand;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    dcnt_d  = dcnt_q;
    en_d    = en_q;
    us_d    = (state_q == ST_CHARGE) ? (us_q + TMR_W'(us_tick)) : '0;
    tmo_d   = err_clr ? '0 : tmo_q;
    flt_d   = (err_clr ? '0 : flt_q) | fault;   // set wins over clear
    pend_d  = pend_q | (key_rise & ~flt_q & ~pend_q & ~sel_mask);

    case (state_q)
      ST_IDLE: begin
        en_d = '0;
        if (|cand) begin
          sel_d   = rr_pick(cand_ext, ptr_q, N_CH);
          ptr_d   = sel_d;
          dcnt_d  = DW'(DEAD_CLK - 1);
          state_d = ST_DEAD;
        end
      end
      ST_DEAD: begin
        en_d = '0;
        if (f_sel) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == '0) begin
          if (v_sel) begin
            // Already charged: release without ever pulsing the enable.
            pend_d  = pend_d & ~sel_oh;
            state_d = ST_IDLE;
          end else begin
            en_d    = sel_oh;
            state_d = ST_CHARGE;
          end
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      ST_CHARGE: begin
        if (f_sel || tmo_hit || v_sel) begin
          en_d    = '0;
          pend_d  = pend_d & ~sel_oh;
          state_d = ST_IDLE;
          if (tmo_hit && !f_sel && !abort_all) tmo_d = tmo_d | sel_oh;
        end
      end
      default: begin
        en_d    = '0;
        state_d = ST_IDLE;
      end
    endcase

    pend_d = pend_d & ~fault;
    if (abort_all) begin
      pend_d  = '0;
      en_d    = '0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= IW'(N_CH - 1);
      dcnt_q  <= '0;
      us_q    <= '0;
      key_q   <= '0;
      pend_q  <= '0;
      flt_q   <= '0;
      tmo_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      dcnt_q  <= dcnt_d;
      us_q    <= us_d;
      key_q   <= key_push;
      pend_q  <= pend_d;
      flt_q   <= flt_d;
      tmo_q   <= tmo_d;
      en_q    <= en_d;
    end
  end

  assign charge_en   = en_q;
  assign pend        = pend_q;
  assign busy        = (state_q != ST_IDLE);
  assign fault_lat   = flt_q;
  assign timeout_err = tmo_q;

endmodule
